// File: rtl/hex2ram_loader.sv
// hex2ram_loader: loads a record stream (addr/data/last) into a RAM write port after an armed trigger edge.
// Latency: one cycle from record acceptance to the W0 write strobe; full throughput for back-to-back records.
// Backpressure: in_ready is high only while loading; optional image checksum via HEX2RAM_LOADER_CHECKSUM_EN.
module hex2ram_loader #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              trigger,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_csum,
    output logic              W0_en,
    output logic [ADDR_W-1:0] W0_addr,
    output logic [DATA_W-1:0] W0_data,
    output logic              W0_mask,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_LOAD  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    // Compare in ADDR_W+1 bits so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic                trig_q;
    logic                w0_en_q;
    logic                w0_mask_q;
    logic [ADDR_W-1:0]   w0_addr_q;
    logic [DATA_W-1:0]   w0_data_q;
    logic                done_q;
    logic                err_q;
    logic [ADDR_W:0]     word_count_q;

    logic                accept;
    logic                in_range;
    logic                wr_fire;
    logic                trig_rise;
    logic                csum_bad;

    assign in_ready  = (state_q == S_LOAD);
    assign accept    = in_valid && in_ready;
    assign in_range  = ({1'b0, in_addr} < DEPTH_L);
    assign wr_fire   = accept && in_range;
    assign trig_rise = trigger && !trig_q;

`ifdef HEX2RAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;

    // The last word takes part in the check, so fold it in before comparing.
    assign csum_bad = ((acc_q ^ in_data) != in_csum);

    // XOR accumulator over every written word of the current image.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (state_q != S_LOAD && state_d == S_LOAD) begin
            acc_q <= '0;
        end else if (wr_fire) begin
            acc_q <= acc_q ^ in_data;
        end
    end
`else
    logic unused_csum;

    assign csum_bad    = 1'b0;
    assign unused_csum = ^in_csum;
`endif

    // Next-state selection; DONE and ERROR only leave through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!arm)           state_d = S_IDLE;
                else if (trig_rise) state_d = S_LOAD;
            end
            S_LOAD: begin
                // arm is deliberately ignored here: a started load runs to completion.
                if (accept) begin
                    if (!in_range)              state_d = S_ERROR;
                    else if (in_last && csum_bad) state_d = S_ERROR;
                    else if (in_last)           state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // State, trigger history and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            trig_q       <= 1'b1;
            w0_en_q      <= 1'b0;
            w0_mask_q    <= 1'b0;
            w0_addr_q    <= '0;
            w0_data_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q   <= state_d;
            trig_q    <= trigger;
            w0_en_q   <= wr_fire;
            w0_mask_q <= wr_fire;
            if (wr_fire) begin
                w0_addr_q <= in_addr;
                w0_data_q <= in_data;
            end
            done_q <= (state_d == S_DONE);
            err_q  <= (state_d == S_ERROR);
            if (wr_fire && (word_count_q != '1)) begin
                word_count_q <= word_count_q + 1'b1;
            end
        end
    end

    assign W0_en      = w0_en_q;
    assign W0_mask    = w0_mask_q;
    assign W0_addr    = w0_addr_q;
    assign W0_data    = w0_data_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_hex2ram_loader.sv
// Testbench for hex2ram_loader: directed steps plus a randomized image load.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Writes are checked against a RAM image and record list built by the bench.
module tb_hex2ram_loader;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_csum = '0;
    logic          W0_en;
    logic [AW-1:0] W0_addr;
    logic [DW-1:0] W0_data;
    logic          W0_mask;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] mram    [DEPTH];
    bit            mwr     [DEPTH];
    logic [DW-1:0] dram    [DEPTH];
    bit            dwr     [DEPTH];
    logic [AW-1:0] rec_a   [40];
    logic [DW-1:0] rec_d   [40];

    hex2ram_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .arm        (arm),
        .trigger    (trigger),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_csum    (in_csum),
        .W0_en      (W0_en),
        .W0_addr    (W0_addr),
        .W0_data    (W0_data),
        .W0_mask    (W0_mask),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input bit ok, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst(input string tag);
        chk({tag, " W0_en"},      W0_en === 1'b0,       W0_en,      1'b0);
        chk({tag, " W0_mask"},    W0_mask === 1'b0,     W0_mask,    1'b0);
        chk({tag, " W0_addr"},    W0_addr === 4'h0,     W0_addr,    4'h0);
        chk({tag, " W0_data"},    W0_data === 16'h0,    W0_data,    16'h0);
        chk({tag, " done"},       done === 1'b0,        done,       1'b0);
        chk({tag, " err"},        err === 1'b0,         err,        1'b0);
        chk({tag, " word_count"}, word_count === 5'h0,  word_count, 5'h0);
        chk({tag, " in_ready"},   in_ready === 1'b0,    in_ready,   1'b0);
    endtask

    task automatic do_reset(input logic trig);
        arm      = 1'b0;
        trigger  = trig;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        in_last  = 1'b0;
        in_csum  = '0;
        reset_n  = 1'b0;
        #1;
        check_rst("reset");
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic start_load();
        arm     = 1'b1;
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        chk("load_entry in_ready", in_ready === 1'b1, in_ready, 1'b1);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last,
                        input logic [DW-1:0] cs, input logic exp_wr, input string tag);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_last  = last;
        in_csum  = cs;
        tick();
        chk({tag, " W0_en"},   W0_en === exp_wr,   W0_en,   exp_wr);
        chk({tag, " W0_mask"}, W0_mask === exp_wr, W0_mask, exp_wr);
        if (exp_wr) begin
            chk({tag, " W0_addr"}, W0_addr === a, W0_addr, a);
            chk({tag, " W0_data"}, W0_data === d, W0_data, d);
        end
    endtask

    initial begin
        logic [DW-1:0] d0, d1, d2, cs;
        int n, idx, cyc;
        logic v;

        #2;
        do_reset(1'b1);
        arm = 1'b1;
        repeat (4) begin
            tick();
            chk("armed_no_edge in_ready", in_ready === 1'b0, in_ready, 1'b0);
        end
        trigger = 1'b0;
        tick();
        chk("trig_low in_ready", in_ready === 1'b0, in_ready, 1'b0);
        trigger = 1'b1;
        tick();
        chk("trig_edge in_ready", in_ready === 1'b1, in_ready, 1'b1);

        d0 = DW'($urandom);
        d1 = DW'($urandom);
        d2 = DW'($urandom);
        cs = d0 ^ d1 ^ d2;
        send(4'd0, d0, 1'b0, cs, 1'b1, "r0");
        chk("r0 word_count", word_count === 5'd1, word_count, 5'd1);
        send(4'd1, d1, 1'b0, cs, 1'b1, "r1");
        send(4'd2, d2, 1'b1, cs, 1'b1, "r2");
        in_valid = 1'b0;
        chk("img3 done",       done === 1'b1,       done,       1'b1);
        chk("img3 err",        err === 1'b0,        err,        1'b0);
        chk("img3 word_count", word_count === 5'd3, word_count, 5'd3);
        chk("img3 in_ready",   in_ready === 1'b0,   in_ready,   1'b0);
        tick();
        chk("img3 after W0_en", W0_en === 1'b0, W0_en, 1'b0);
        chk("img3 after done",  done === 1'b1,  done,  1'b1);

        do_reset(1'b0);
        start_load();
        send(4'd5, DW'($urandom), 1'b0, 16'h0, 1'b1, "pre_oob");
        send(AW'(DEPTH), DW'($urandom), 1'b0, 16'h0, 1'b0, "oob");
        chk("oob err",        err === 1'b1,        err,        1'b1);
        chk("oob done",       done === 1'b0,       done,       1'b0);
        chk("oob in_ready",   in_ready === 1'b0,   in_ready,   1'b0);
        chk("oob word_count", word_count === 5'd1, word_count, 5'd1);
        in_addr = 4'd3;
        repeat (3) begin
            tick();
            chk("post_oob W0_en", W0_en === 1'b0, W0_en, 1'b0);
            chk("post_oob err",   err === 1'b1,   err,   1'b1);
        end
        in_valid = 1'b0;

        do_reset(1'b0);
        start_load();
        send(4'd3, DW'($urandom), 1'b0, 16'h0, 1'b1, "pre_rst");
        in_valid = 1'b1;
        in_addr  = 4'd4;
        in_data  = DW'($urandom);
        #2;
        reset_n = 1'b0;
        #1;
        check_rst("midload_rst");
        tick();
        tick();
        reset_n = 1'b1;
        repeat (4) begin
            tick();
            chk("post_rst W0_en",    W0_en === 1'b0,    W0_en,    1'b0);
            chk("post_rst in_ready", in_ready === 1'b0, in_ready, 1'b0);
        end
        in_valid = 1'b0;

        do_reset(1'b0);
        arm = 1'b1;
        tick();
        arm      = 1'b0;
        trigger  = 1'b1;
        in_valid = 1'b1;
        in_addr  = 4'd1;
        repeat (3) begin
            tick();
            chk("arm_drop in_ready", in_ready === 1'b0, in_ready, 1'b0);
            chk("arm_drop W0_en",    W0_en === 1'b0,    W0_en,    1'b0);
        end
        arm = 1'b1;
        repeat (3) begin
            tick();
            chk("rearm_no_edge in_ready", in_ready === 1'b0, in_ready, 1'b0);
        end
        in_valid = 1'b0;

`ifdef HEX2RAM_LOADER_CHECKSUM_EN
        do_reset(1'b0);
        start_load();
        send(4'd0, 16'h1, 1'b0, 16'h3, 1'b1, "cs_ok0");
        send(4'd1, 16'h2, 1'b1, 16'h3, 1'b1, "cs_ok1");
        in_valid = 1'b0;
        chk("cs_ok done", done === 1'b1, done, 1'b1);
        chk("cs_ok err",  err === 1'b0,  err,  1'b0);
        do_reset(1'b0);
        start_load();
        send(4'd0, 16'h1, 1'b0, 16'h0, 1'b1, "cs_bad0");
        send(4'd1, 16'h2, 1'b1, 16'h0, 1'b1, "cs_bad1");
        in_valid = 1'b0;
        chk("cs_bad err",        err === 1'b1,        err,        1'b1);
        chk("cs_bad done",       done === 1'b0,       done,       1'b0);
        chk("cs_bad word_count", word_count === 5'd2, word_count, 5'd2);
`else
        do_reset(1'b0);
        start_load();
        send(4'd0, 16'h1, 1'b0, 16'h0, 1'b1, "cs_ign0");
        send(4'd1, 16'h2, 1'b1, 16'h0, 1'b1, "cs_ign1");
        in_valid = 1'b0;
        chk("cs_ign done", done === 1'b1, done, 1'b1);
        chk("cs_ign err",  err === 1'b0,  err,  1'b0);
`endif

        do_reset(1'b0);
        start_load();
        for (int a = 0; a < DEPTH; a++) begin
            mram[a] = '0;
            mwr[a]  = 1'b0;
            dram[a] = '0;
            dwr[a]  = 1'b0;
        end
        n  = int'($urandom_range(12, 6));
        cs = '0;
        for (int i = 0; i < n; i++) begin
            rec_a[i] = AW'($urandom_range(DEPTH - 1, 0));
            rec_d[i] = DW'($urandom);
            cs       = cs ^ rec_d[i];
        end
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 300) begin
            if (cyc == 3) arm = 1'b0;
            if (cyc == 5) trigger = 1'b0;
            if (cyc == 6) trigger = 1'b1;
            v        = ($urandom_range(3, 0) != 0);
            in_valid = v;
            in_addr  = rec_a[idx];
            in_data  = rec_d[idx];
            in_last  = (idx == n - 1);
            in_csum  = cs;
            tick();
            chk("rand W0_en", W0_en === v, W0_en, v);
            if (W0_en) begin
                dram[W0_addr] = W0_data;
                dwr[W0_addr]  = 1'b1;
            end
            if (v) begin
                mram[rec_a[idx]] = rec_d[idx];
                mwr[rec_a[idx]]  = 1'b1;
                idx++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand all_sent",   idx === n,                   idx,        n);
        chk("rand done",       done === 1'b1,               done,       1'b1);
        chk("rand err",        err === 1'b0,                err,        1'b0);
        chk("rand word_count", word_count === (AW+1)'(n),   word_count, (AW+1)'(n));
        for (int a = 0; a < DEPTH; a++) begin
            chk($sformatf("rand ram_wr[%0d]", a), dwr[a] === mwr[a],   dwr[a],  mwr[a]);
            chk($sformatf("rand ram[%0d]", a),    dram[a] === mram[a], dram[a], mram[a]);
        end

        do_reset(1'b0);
        start_load();
        cs = '0;
        for (int i = 0; i < 35; i++) begin
            rec_d[i] = DW'($urandom);
            cs       = cs ^ rec_d[i];
        end
        for (int i = 0; i < 35; i++) begin
            send(AW'(i % DEPTH), rec_d[i], (i == 34), cs, 1'b1, "sat");
        end
        in_valid = 1'b0;
        chk("sat word_count", word_count === 5'h1F, word_count, 5'h1F);
        chk("sat done",       done === 1'b1,        done,       1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
